// File: rtl/conv_pkg.sv
// Shared types and helpers for the psum plane accumulator.
// FSM encoding, saturation bounds and address-width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  function automatic int addr_w(input int max_size);
    return $clog2(max_size * max_size);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam int     OUT_W_DEF = 32;
  localparam longint SAT_MAX   = sat_max(OUT_W_DEF);
  localparam longint SAT_MIN   = sat_min(OUT_W_DEF);

endpackage

// File: rtl/psum_plane_accum_if.sv
// Psum input stream and result output stream, valid/ready.
// master drives psums and out_ready; slave is the accumulator.
interface psum_plane_accum_if #(
  parameter int DATA_WIDTH = 48,
  parameter int OUT_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_psum;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/psum_plane_ram.sv
// Plane buffer: DEPTH x DATA_WIDTH register array, no reset.
// Ports: clk, we/addr/wdata sync write, rdata async read at addr.
module psum_plane_ram #(
  parameter int DEPTH      = 4624,
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/psum_plane_accum.sv
// Accumulates one psum plane over C channels, then ReLU/saturate out.
// Ports: clk1, rst_n (sync, active-high), start/cfg_*, bus, busy/done/cfg_err.
module psum_plane_accum
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 48,
  parameter int OUT_WIDTH    = 32,
  parameter int MAX_OUT_SIZE = 68,
  parameter int MAX_CI       = 16
) (
  input  logic                              clk1,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_OUT_SIZE+1)-1:0] cfg_out_size,
  input  logic [$clog2(MAX_CI+1)-1:0]       cfg_ci,
  input  logic                              cfg_relu,
  psum_plane_accum_if.slave                 bus,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err
);
  localparam int NW    = $clog2(MAX_OUT_SIZE + 1);
  localparam int CW    = $clog2(MAX_CI + 1);
  localparam int AW    = addr_w(MAX_OUT_SIZE);
  localparam int DEPTH = MAX_OUT_SIZE * MAX_OUT_SIZE;

  localparam logic [NW-1:0] N_MAX = NW'(MAX_OUT_SIZE);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_CI);

  localparam logic signed [DATA_WIDTH-1:0] SAT_HI =
    DATA_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] SAT_LO =
    DATA_WIDTH'(sat_min(OUT_WIDTH));

  state_e                state;
  logic [CW-1:0]         c_q;
  logic                  relu_q;
  logic [AW-1:0]         last_pix;
  logic [AW-1:0]         pix_cnt;
  logic [CW-1:0]         ch_cnt;
  logic                  ov_q;
  logic [OUT_WIDTH-1:0]  od_q;
  logic                  ol_q;

  logic                  last_ch;
  logic                  in_ready;
  logic                  in_fire;
  logic                  out_fire;
  logic                  cfg_ok;
  logic [2*NW-1:0]       sq;
  logic [DATA_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] relu_v;
  logic [OUT_WIDTH-1:0]  sat_v;

  assign last_ch  = (ch_cnt == c_q - 1'b1);
  // Last channel feeds the one-entry output register.
  assign in_ready = (state == ACCUM) &&
                    (!last_ch || !ov_q || bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = ov_q && bus.out_ready;

  // Channel 0 overwrites, so C==1 also takes the raw psum.
  assign sum = (ch_cnt == '0) ? bus.in_psum : rd + bus.in_psum;

  assign cfg_ok = (cfg_out_size != '0) && (cfg_out_size <= N_MAX) &&
                  (cfg_ci != '0) && (cfg_ci <= C_MAX);
  assign sq = {{NW{1'b0}}, cfg_out_size} * {{NW{1'b0}}, cfg_out_size};

  always_comb begin
    relu_v = (relu_q && sum[DATA_WIDTH-1]) ? '0 : sum;
    if ($signed(relu_v) > SAT_HI)
      sat_v = OUT_WIDTH'(SAT_HI);
    else if ($signed(relu_v) < SAT_LO)
      sat_v = OUT_WIDTH'(SAT_LO);
    else
      sat_v = relu_v[OUT_WIDTH-1:0];
  end

  psum_plane_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk1),
    .we    (in_fire && !last_ch),
    .addr  (pix_cnt),
    .wdata (sum),
    .rdata (rd)
  );

  always_ff @(posedge clk1) begin
    if (rst_n) begin
      state    <= IDLE;
      c_q      <= '0;
      relu_q   <= 1'b0;
      last_pix <= '0;
      pix_cnt  <= '0;
      ch_cnt   <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ol_q     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (in_fire && last_ch) begin
        ov_q <= 1'b1;
        od_q <= sat_v;
        ol_q <= (pix_cnt == last_pix);
      end else if (out_fire) begin
        ov_q <= 1'b0;
        ol_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              c_q      <= cfg_ci;
              relu_q   <= cfg_relu;
              last_pix <= AW'(sq - 1'b1);
              pix_cnt  <= '0;
              ch_cnt   <= '0;
              state    <= ACCUM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            if (pix_cnt == last_pix) begin
              pix_cnt <= '0;
              if (last_ch) state <= DRAIN;
              else ch_cnt <= ch_cnt + 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire && ol_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = ol_q;

endmodule

// File: tb/tb_psum_plane_accum.sv
// Directed bench for psum_plane_accum (OUT_WIDTH=8, MAX 4x4, MAX_CI=4).
// Hand-computed plane results, handshake timing, errors, reset.
module tb_psum_plane_accum;
  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] cfg_out_size;
  logic [2:0] cfg_ci;
  logic       cfg_relu;
  logic       busy;
  logic       done;
  logic       cfg_err;
  int total = 0;
  int bad   = 0;

  psum_plane_accum_if #(.DATA_WIDTH(48), .OUT_WIDTH(8)) bus ();

  psum_plane_accum #(
    .DATA_WIDTH   (48),
    .OUT_WIDTH    (8),
    .MAX_OUT_SIZE (4),
    .MAX_CI       (4)
  ) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_out_size (cfg_out_size),
    .cfg_ci       (cfg_ci),
    .cfg_relu     (cfg_relu),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_cfg(input int n, input int c, input bit r);
    @(negedge clk1);
    start        = 1'b1;
    cfg_out_size = 3'(n);
    cfg_ci       = 3'(c);
    cfg_relu     = r;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic run_plane(input int n, input int c, input bit r,
                           input int ps[$], input int ex[$],
                           input int stall_at, input int stall_len);
    int idx = 0;
    int got = 0;
    int stl = 0;
    int cyc = 0;
    int pre = (c - 1) * n * n;
    bit pend = 1'b0;
    longint held = 0;
    start_cfg(n, c, r);
    chk("busy_start", busy, 1);
    chk("rdy_start", bus.in_ready, 1);
    while (got < ex.size() && cyc < 300) begin
      if (pend) chk("latency", bus.out_valid, 1);
      bus.in_valid  = (idx < ps.size());
      bus.in_psum   = (idx < ps.size()) ? 48'(longint'(ps[idx])) : '0;
      bus.out_ready = !(got == stall_at && stl < stall_len &&
                        bus.out_valid);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        if (stl > 0) chk("bp_hold", $signed(bus.out_data), held);
        held = $signed(bus.out_data);
        chk("bp_rdy", bus.in_ready, 0);
        stl++;
      end
      if (bus.in_valid && idx < pre) chk("rdy_pre", bus.in_ready, 1);
      pend = bus.in_valid && bus.in_ready && idx >= pre;
      if (bus.out_valid && bus.out_ready) begin
        chk("data", $signed(bus.out_data), ex[got]);
        chk("last", bus.out_last, (got == ex.size() - 1) ? 1 : 0);
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk1);
      cyc++;
    end
    if (got < ex.size()) chk("timeout_beats", got, ex.size());
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_pulse", done, 1);
    chk("ov_after", bus.out_valid, 0);
    @(negedge clk1);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
  endtask

  task automatic bad_cfg(input int n, input int c);
    start_cfg(n, c, 1'b0);
    chk("cfg_err", cfg_err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk1);
    chk("err_clr", cfg_err, 0);
    chk("err_idle", busy, 0);
  endtask

  initial begin
    rst_n         = 1'b1;
    start         = 1'b0;
    cfg_out_size  = '0;
    cfg_ci        = '0;
    cfg_relu      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b0;
    @(negedge clk1);

    run_plane(2, 1, 0, '{5, -3, 7, -9}, '{5, -3, 7, -9}, -1, 0);
    run_plane(2, 3, 0, '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10},
              '{30, 30, 30, 30}, -1, 0);
    run_plane(2, 2, 1, '{-4, 2, 0, 1, 1, -5, 0, -1},
              '{0, 0, 0, 0}, -1, 0);
    run_plane(2, 2, 0, '{-4, 2, 0, 1, 1, -5, 0, -1},
              '{-3, -3, 0, 0}, -1, 0);
    run_plane(1, 2, 0, '{100, 100}, '{127}, -1, 0);
    run_plane(1, 2, 0, '{-100, -100}, '{-128}, -1, 0);
    run_plane(1, 2, 1, '{-100, -100}, '{0}, -1, 0);
    run_plane(2, 1, 0, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 1, 3);
    run_plane(4, 1, 0,
              '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
              '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
              -1, 0);

    bad_cfg(2, 0);
    bad_cfg(0, 2);
    bad_cfg(5, 1);
    bad_cfg(1, 5);

    // Abort after two channel-1 beats of an N=2, C=2 plane.
    start_cfg(2, 2, 1'b0);
    begin
      int sent = 0;
      int guard = 0;
      int ps[$] = '{1, 2, 3, 4, 5, 6};
      while (sent < 6 && guard < 50) begin
        bus.in_valid = 1'b1;
        bus.in_psum  = 48'(longint'(ps[sent]));
        #1;
        if (bus.in_ready) sent++;
        @(negedge clk1);
        guard++;
      end
      if (sent < 6) chk("timeout_abort", sent, 6);
    end
    bus.in_valid = 1'b0;
    chk("pre_abort_ov", bus.out_valid, 1);
    rst_n = 1'b1;
    @(negedge clk1);
    rst_n = 1'b0;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_out_last", bus.out_last, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk1);
    run_plane(1, 2, 0, '{3, 4}, '{7}, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
